rv32im_trap_seq: RTL

Trap/return sequencer and port arbiter for the machine-mode CSR unit. It owns the single CSR access port and shares it between the pipeline's Zicsr instructions and its own multi-cycle trap entry and `mret` sequences. On trap entry it saves `mepc`/`mcause`/`mtval`, updates `mstatus`, reads `mtvec`, and issues a PC redirect. It sits between decode/execute and `rv32im_csr`.

---
 rtl/rv32im_trap_seq_pkg.sv | 68 ++++++
 rtl/rv32im_trap_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rv32im_trap_seq_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// mstatus bit positions, CSR port opcodes, FSM states and mstatus/target helpers.
package rv32im_trap_seq_pkg;

    localparam int CSR_OPCODE_WIDTH = 2;

    localparam logic [CSR_OPCODE_WIDTH-1:0] CSR_OP_NONE = 2'd0;
    localparam logic [CSR_OPCODE_WIDTH-1:0] CSR_OP_RW   = 2'd1;
    localparam logic [CSR_OPCODE_WIDTH-1:0] CSR_OP_RS   = 2'd2;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T_EPC,
        ST_T_CAUSE,
        ST_T_TVAL,
        ST_T_ST_RD,
        ST_T_ST_WAIT,
        ST_T_ST_WR,
        ST_T_VEC_RD,
        ST_T_VEC_WAIT,
        ST_REDIR,
        ST_R_ST_RD,
        ST_R_ST_WAIT,
        ST_R_ST_WR,
        ST_R_EPC_RD,
        ST_R_EPC_WAIT
    } seq_state_e;

    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // Vectored mode only applies to interrupts; modes 2/3 fall back to direct.
    function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                                input logic [31:0] cause);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (mtvec[1:0] == 2'b01 && cause[31])
            return base + {cause[29:0], 2'b00};
        return base;
    endfunction

endpackage

// File: rtl/rv32im_trap_seq.sv
// Owns the CSR access port: forwards pipeline Zicsr accesses when idle and runs
// the multi-cycle trap-entry and mret sequences, ending each with a PC redirect.
module rv32im_trap_seq
    import rv32im_trap_seq_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        trap_req_i,
    input  logic [31:0]                 trap_cause_i,
    input  logic [31:0]                 trap_pc_i,
    input  logic [31:0]                 trap_tval_i,
    input  logic                        mret_req_i,
    output logic                        trap_ack_o,
    output logic                        mret_ack_o,
    input  logic                        ins_req_i,
    input  logic [11:0]                 ins_addr_i,
    input  logic [31:0]                 ins_wdata_i,
    input  logic [CSR_OPCODE_WIDTH-1:0] ins_op_i,
    input  logic                        ins_we_i,
    input  logic                        ins_re_i,
    output logic                        ins_gnt_o,
    output logic [11:0]                 csr_addr_o,
    output logic [31:0]                 csr_wdata_o,
    output logic [CSR_OPCODE_WIDTH-1:0] csr_op_o,
    output logic                        csr_we_o,
    output logic                        csr_re_o,
    input  logic [31:0]                 csr_rdata_i,
    output logic                        redirect_valid_o,
    output logic [31:0]                 redirect_pc_o,
    output logic                        busy_o
);

    localparam logic [2:0] RD_LAT_CNT = 3'(RD_LAT);

    seq_state_e  state_reg, state_next;
    logic [2:0]  cnt_reg;
    logic [31:0] epc_reg, cause_reg, tval_reg;
    logic [31:0] mstatus_reg, target_reg;

    logic        seq_wr, seq_rd;
    logic [11:0] seq_addr;
    logic [31:0] seq_wdata;
    logic        rd_done;

    assign rd_done = (cnt_reg <= 3'd1);

    always_comb begin
        state_next       = state_reg;
        seq_wr           = 1'b0;
        seq_rd           = 1'b0;
        seq_addr         = '0;
        seq_wdata        = '0;
        trap_ack_o       = 1'b0;
        mret_ack_o       = 1'b0;
        ins_gnt_o        = 1'b0;
        csr_addr_o       = '0;
        csr_wdata_o      = '0;
        csr_op_o         = CSR_OP_NONE;
        csr_we_o         = 1'b0;
        csr_re_o         = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        busy_o           = (state_reg != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                if (trap_req_i) begin
                    trap_ack_o = 1'b1;
                    state_next = ST_T_EPC;
                end else if (mret_req_i) begin
                    mret_ack_o = 1'b1;
                    state_next = ST_R_ST_RD;
                end else if (ins_req_i) begin
                    ins_gnt_o   = 1'b1;
                    csr_addr_o  = ins_addr_i;
                    csr_wdata_o = ins_wdata_i;
                    csr_op_o    = ins_op_i;
                    csr_we_o    = ins_we_i;
                    csr_re_o    = ins_re_i;
                end
            end
            ST_T_EPC: begin
                seq_wr = 1'b1; seq_addr = CSR_MEPC; seq_wdata = epc_reg;
                state_next = ST_T_CAUSE;
            end
            ST_T_CAUSE: begin
                seq_wr = 1'b1; seq_addr = CSR_MCAUSE; seq_wdata = cause_reg;
                state_next = ST_T_TVAL;
            end
            ST_T_TVAL: begin
                seq_wr = 1'b1; seq_addr = CSR_MTVAL; seq_wdata = tval_reg;
                state_next = ST_T_ST_RD;
            end
            ST_T_ST_RD: begin
                seq_rd = 1'b1; seq_addr = CSR_MSTATUS;
                state_next = ST_T_ST_WAIT;
            end
            ST_T_ST_WAIT:  if (rd_done) state_next = ST_T_ST_WR;
            ST_T_ST_WR: begin
                seq_wr = 1'b1; seq_addr = CSR_MSTATUS; seq_wdata = mstatus_reg;
                state_next = ST_T_VEC_RD;
            end
            ST_T_VEC_RD: begin
                seq_rd = 1'b1; seq_addr = CSR_MTVEC;
                state_next = ST_T_VEC_WAIT;
            end
            ST_T_VEC_WAIT: if (rd_done) state_next = ST_REDIR;
            ST_REDIR: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = target_reg;
                state_next       = ST_IDLE;
            end
            ST_R_ST_RD: begin
                seq_rd = 1'b1; seq_addr = CSR_MSTATUS;
                state_next = ST_R_ST_WAIT;
            end
            ST_R_ST_WAIT:  if (rd_done) state_next = ST_R_ST_WR;
            ST_R_ST_WR: begin
                seq_wr = 1'b1; seq_addr = CSR_MSTATUS; seq_wdata = mstatus_reg;
                state_next = ST_R_EPC_RD;
            end
            ST_R_EPC_RD: begin
                seq_rd = 1'b1; seq_addr = CSR_MEPC;
                state_next = ST_R_EPC_WAIT;
            end
            ST_R_EPC_WAIT: if (rd_done) state_next = ST_REDIR;
            default:       state_next = ST_IDLE;
        endcase

        if (seq_wr) begin
            csr_addr_o  = seq_addr;
            csr_wdata_o = seq_wdata;
            csr_op_o    = CSR_OP_RW;
            csr_we_o    = 1'b1;
        end else if (seq_rd) begin
            csr_addr_o  = seq_addr;
            csr_op_o    = CSR_OP_RS;
            csr_re_o    = 1'b1;
        end

        // Outputs are combinational from inputs too, so silence them while reset is held.
        if (!rst_n_i) begin
            trap_ack_o       = 1'b0;
            mret_ack_o       = 1'b0;
            ins_gnt_o        = 1'b0;
            csr_addr_o       = '0;
            csr_wdata_o      = '0;
            csr_op_o         = CSR_OP_NONE;
            csr_we_o         = 1'b0;
            csr_re_o         = 1'b0;
            redirect_valid_o = 1'b0;
            redirect_pc_o    = '0;
            busy_o           = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            epc_reg     <= '0;
            cause_reg   <= '0;
            tval_reg    <= '0;
            mstatus_reg <= '0;
            target_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (trap_ack_o) begin
                epc_reg   <= {trap_pc_i[31:2], 2'b00};
                cause_reg <= trap_cause_i;
                tval_reg  <= trap_tval_i;
            end
            case (state_reg)
                ST_T_ST_RD, ST_T_VEC_RD, ST_R_ST_RD, ST_R_EPC_RD: cnt_reg <= RD_LAT_CNT;
                ST_T_ST_WAIT: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (rd_done) mstatus_reg <= trap_mstatus(csr_rdata_i);
                end
                ST_T_VEC_WAIT: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (rd_done) target_reg <= trap_target(csr_rdata_i, cause_reg);
                end
                ST_R_ST_WAIT: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (rd_done) mstatus_reg <= mret_mstatus(csr_rdata_i);
                end
                ST_R_EPC_WAIT: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (rd_done) target_reg <= {csr_rdata_i[31:2], 2'b00};
                end
                default: ;
            endcase
        end
    end

endmodule
